vram_arbiter: RTL and testbench

//  Shares the single-port VDC VRAM (32K x 16, 1-cycle synchronous read) between four requesters:
//  BG fetch, SPR fetch, CPU port (VWR/VRR path) and VRAM-VRAM DMA.

---
 rtl/vdc_pkg.sv | 17 +
 rtl/vram_rr2.sv | 73 +++++++
 rtl/vram_arbiter.sv | 134 +++++++++++++
 tb/tb_vram_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/vdc_pkg.sv
// Shared VDC types for the VRAM arbiter and its helpers.
package vdc_pkg;

   typedef enum logic [1:0] {
      REQ_BG  = 2'd0,
      REQ_SPR = 2'd1,
      REQ_CPU = 2'd2,
      REQ_DMA = 2'd3
   } req_id_t;

   typedef logic [15:0] vram_word_t;
   typedef logic [14:0] vram_addr_t;

   localparam int NUM_VRAM_REQ = 4;
   localparam int WAIT_CNT_W   = 8;

endpackage

// File: rtl/vram_rr2.sv
// CPU/DMA round-robin pointer plus saturating starvation counters.
// Produces the low-priority pick; starved_o flags that the pick outranks SPR.
module vram_rr2
   import vdc_pkg::*;
#(
   parameter int STARVE_LIMIT = 8
) (
   input  logic    clk_i,
   input  logic    rst_i,
   input  logic    cpu_req_i,
   input  logic    dma_req_i,
   input  logic    cpu_gnt_i,
   input  logic    dma_gnt_i,
   output logic    pick_vld_o,
   output req_id_t pick_o,
   output logic    starved_o
);

   localparam logic [WAIT_CNT_W-1:0] LIMIT   = WAIT_CNT_W'(STARVE_LIMIT);
   localparam logic [WAIT_CNT_W-1:0] CNT_MAX = '1;

   logic                  ptr_q, ptr_d;          // 0: CPU preferred, 1: DMA preferred
   logic [WAIT_CNT_W-1:0] cpu_wait_q, cpu_wait_d;
   logic [WAIT_CNT_W-1:0] dma_wait_q, dma_wait_d;
   logic                  cpu_starved, dma_starved;
   logic                  cand_cpu, cand_dma;

   assign cpu_starved = cpu_req_i && (cpu_wait_q >= LIMIT);
   assign dma_starved = dma_req_i && (dma_wait_q >= LIMIT);

   // Pick among starved requesters first; otherwise among all CPU/DMA requesters.
   always_comb begin
      cand_cpu  = cpu_req_i;
      cand_dma  = dma_req_i;
      starved_o = 1'b0;
      if (cpu_starved || dma_starved) begin
         cand_cpu  = cpu_starved;
         cand_dma  = dma_starved;
         starved_o = 1'b1;
      end
      pick_vld_o = cand_cpu || cand_dma;
      pick_o     = REQ_CPU;
      if (cand_cpu && cand_dma) pick_o = ptr_q ? REQ_DMA : REQ_CPU;
      else if (cand_dma)        pick_o = REQ_DMA;
   end

   // Next pointer flips away from whoever was just served; waits count while ignored.
   always_comb begin
      ptr_d      = ptr_q;
      cpu_wait_d = '0;
      dma_wait_d = '0;
      if (cpu_gnt_i)      ptr_d = 1'b1;
      else if (dma_gnt_i) ptr_d = 1'b0;
      if (cpu_req_i && !cpu_gnt_i)
         cpu_wait_d = (cpu_wait_q == CNT_MAX) ? CNT_MAX : cpu_wait_q + 1'b1;
      if (dma_req_i && !dma_gnt_i)
         dma_wait_d = (dma_wait_q == CNT_MAX) ? CNT_MAX : dma_wait_q + 1'b1;
   end

   // Pointer and counter registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q      <= 1'b0;
         cpu_wait_q <= '0;
         dma_wait_q <= '0;
      end else begin
         ptr_q      <= ptr_d;
         cpu_wait_q <= cpu_wait_d;
         dma_wait_q <= dma_wait_d;
      end
   end

endmodule

// File: rtl/vram_arbiter.sv
// VDC VRAM arbiter: one access per clock among BG, SPR, CPU and DMA.
// Optional VRAM_PERF_CNT_EN adds per-requester grant and stall counters.
module vram_arbiter
   import vdc_pkg::*;
#(
   parameter int ADDR_W       = 15,
   parameter int DATA_W       = 16,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                                 clock_i,
   input  logic                                 reset_i,
   input  logic [NUM_VRAM_REQ-1:0]              req_i,
   input  logic [NUM_VRAM_REQ-1:0]              req_we_i,
   input  logic [NUM_VRAM_REQ-1:0][15:0]        req_addr_i,
   input  logic [NUM_VRAM_REQ-1:0][DATA_W-1:0]  req_wdata_i,
   output logic [NUM_VRAM_REQ-1:0]              gnt_o,
   output logic [NUM_VRAM_REQ-1:0]              rvalid_o,
   output logic [DATA_W-1:0]                    rdata_o,
   output logic [ADDR_W-1:0]                    vram_addr_o,
   output logic [DATA_W-1:0]                    vram_wdata_o,
   output logic                                 vram_wren_o,
   input  logic [DATA_W-1:0]                    vram_q_i
`ifdef VRAM_PERF_CNT_EN
   ,
   output logic [NUM_VRAM_REQ-1:0][31:0]        perf_gnt_cnt_o,
   output logic [31:0]                          perf_stall_cnt_o
`endif
);

   logic                    lp_vld, lp_starved;
   req_id_t                 lp_pick, gnt_id;
   logic                    any_gnt, sel_oor;
   logic [15:0]             sel_addr;
   logic [NUM_VRAM_REQ-1:0] rvld_q, rvld_d;
   logic                    rd_oor_q, rd_oor_d;
   logic [DATA_W-1:0]       rdata_q, rdata_d;
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic [DATA_W-1:0]       wdata_q, wdata_d;

   vram_rr2 #(.STARVE_LIMIT(STARVE_LIMIT)) u_rr2 (
      .clk_i      (clock_i),
      .rst_i      (reset_i),
      .cpu_req_i  (req_i[REQ_CPU]),
      .dma_req_i  (req_i[REQ_DMA]),
      .cpu_gnt_i  (gnt_o[REQ_CPU]),
      .dma_gnt_i  (gnt_o[REQ_DMA]),
      .pick_vld_o (lp_vld),
      .pick_o     (lp_pick),
      .starved_o  (lp_starved)
   );

   // Fixed priority BG > starved CPU/DMA > SPR > CPU/DMA round-robin.
   always_comb begin
      gnt_o = '0;
      if (!reset_i) begin
         if (req_i[REQ_BG])       gnt_o[REQ_BG]  = 1'b1;
         else if (lp_starved)     gnt_o[lp_pick] = 1'b1;
         else if (req_i[REQ_SPR]) gnt_o[REQ_SPR] = 1'b1;
         else if (lp_vld)         gnt_o[lp_pick] = 1'b1;
      end
   end

   // Encode the one-hot grant to select the winner's address/data.
   always_comb begin
      gnt_id = REQ_BG;
      for (int i = 0; i < NUM_VRAM_REQ; i++)
         if (gnt_o[i]) gnt_id = req_id_t'(2'(i));
   end

   assign any_gnt  = |gnt_o;
   assign sel_addr = req_addr_i[gnt_id];
   assign sel_oor  = sel_addr[15];

   // BRAM drive: winner passes straight through; idle cycles replay the last address/data.
   always_comb begin
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      if (any_gnt) begin
         addr_d  = sel_addr[ADDR_W-1:0];
         wdata_d = req_wdata_i[gnt_id];
      end
      vram_addr_o  = addr_d;
      vram_wdata_o = wdata_d;
      vram_wren_o  = any_gnt && req_we_i[gnt_id] && !sel_oor;
   end

   // Read return: out-of-range reads still answer, but with zero data.
   always_comb begin
      rvld_d   = gnt_o & ~req_we_i;
      rd_oor_d = sel_oor;
      rvalid_o = reset_i ? '0 : rvld_q;
      rdata_d  = rdata_q;
      if (|rvalid_o) rdata_d = rd_oor_q ? '0 : vram_q_i;
      rdata_o  = rdata_d;
   end

   // Pipeline and hold registers.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         rvld_q   <= '0;
         rd_oor_q <= 1'b0;
         rdata_q  <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         rvld_q   <= rvld_d;
         rd_oor_q <= rd_oor_d;
         rdata_q  <= rdata_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
      end
   end

`ifdef VRAM_PERF_CNT_EN
   logic [NUM_VRAM_REQ-1:0][31:0] perf_gnt_q;
   logic [31:0]                   perf_stall_q;

   // Wrapping grant counters and a count of cycles where someone was left waiting.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         perf_gnt_q   <= '0;
         perf_stall_q <= '0;
      end else begin
         for (int i = 0; i < NUM_VRAM_REQ; i++)
            perf_gnt_q[i] <= perf_gnt_q[i] + 32'(gnt_o[i]);
         perf_stall_q <= perf_stall_q + 32'(|(req_i & ~gnt_o));
      end
   end

   assign perf_gnt_cnt_o   = perf_gnt_q;
   assign perf_stall_cnt_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios then randomized traffic,
// all checked against a rule-level model with its own shadow memory.
module tb_vram_arbiter;
   import vdc_pkg::*;

   localparam int LIM = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic [3:0]       req, we;
   logic [3:0][15:0] addr, wd;
   logic [3:0]       gnt, rvalid;
   logic [15:0]      rdata;
   logic [14:0]      vaddr;
   logic [15:0]      vwdata;
   logic             vwren;
   logic [15:0]      vq;

   logic [15:0] bram   [0:32767];
   logic [15:0] shadow [0:32767];

   int ncmp = 0, nfail = 0;
   int m_wc [4];
   int m_rr, m_pend, m_lastg;
   logic [15:0] m_pdata, m_hold, m_lwdata;
   logic [14:0] m_laddr;
   logic [3:0]  obs_g, obs_rv;
   logic [15:0] obs_rd, obs_wd;
   logic [14:0] obs_addr;
   logic        obs_wren;

   always #5 clk = ~clk;

   // BRAM model: 1-cycle synchronous read.
   always @(posedge clk) begin
      if (vwren) bram[vaddr] <= vwdata;
      vq <= bram[vaddr];
   end

   vram_arbiter dut (
      .clock_i(clk), .reset_i(rst), .req_i(req), .req_we_i(we),
      .req_addr_i(addr), .req_wdata_i(wd), .gnt_o(gnt), .rvalid_o(rvalid),
      .rdata_o(rdata), .vram_addr_o(vaddr), .vram_wdata_o(vwdata),
      .vram_wren_o(vwren), .vram_q_i(vq)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Winner from the priority rules, -1 for none.
   function automatic int mpick();
      bit s2, s3;
      if (rst) return -1;
      if (req[0]) return 0;
      s2 = req[2] && (m_wc[2] >= LIM);
      s3 = req[3] && (m_wc[3] >= LIM);
      if (s2 && s3) return m_rr;
      if (s2) return 2;
      if (s3) return 3;
      if (req[1]) return 1;
      if (req[2] && req[3]) return m_rr;
      if (req[2]) return 2;
      if (req[3]) return 3;
      return -1;
   endfunction

   task automatic mreset();
      foreach (m_wc[i]) m_wc[i] = 0;
      m_rr = 2; m_pend = -1; m_hold = '0; m_laddr = '0; m_lwdata = '0; m_lastg = -1;
   endtask

   // One clock: entered at posedge+1 with inputs set, checks mid-cycle, leaves at next posedge+1.
   task automatic cyc();
      int g;
      logic [3:0] eg, erv;
      logic ewren;
      #3;
      g   = mpick();
      eg  = (g < 0) ? 4'b0 : 4'(1 << g);
      erv = (rst || m_pend < 0) ? 4'b0 : 4'(1 << m_pend);
      if (erv != 4'b0) m_hold = m_pdata;
      obs_g = gnt; obs_rv = rvalid; obs_rd = rdata; obs_wren = vwren;
      obs_addr = vaddr; obs_wd = vwdata;
      chk("gnt", 32'(gnt), 32'(eg));
      chk("rvalid", 32'(rvalid), 32'(erv));
      if (!rst) begin
         ewren = 1'b0;
         if (g >= 0) begin
            m_laddr  = addr[g][14:0];
            m_lwdata = wd[g];
            ewren    = we[g] && !addr[g][15];
         end
         chk("rdata", 32'(rdata), 32'(m_hold));
         chk("wren", 32'(vwren), 32'(ewren));
         chk("vaddr", 32'(vaddr), 32'(m_laddr));
         chk("vwdata", 32'(vwdata), 32'(m_lwdata));
      end
      if (rst) mreset();
      else begin
         m_pend = -1;
         if (g >= 0) begin
            if (we[g]) begin
               if (!addr[g][15]) shadow[addr[g][14:0]] = wd[g];
            end else begin
               m_pend  = g;
               m_pdata = addr[g][15] ? 16'h0000 : shadow[addr[g][14:0]];
            end
            if (g == 2) m_rr = 3;
            else if (g == 3) m_rr = 2;
         end
         for (int i = 2; i < 4; i++)
            m_wc[i] = (req[i] && g != i) ? ((m_wc[i] < 255) ? m_wc[i] + 1 : 255) : 0;
         m_lastg = g;
      end
      @(posedge clk); #1;
   endtask

   task automatic put(input int i, input logic w, input logic [15:0] a, input logic [15:0] d);
      req[i] = 1'b1; we[i] = w; addr[i] = a; wd[i] = d;
   endtask

   initial begin
      int pr [4];
      mreset();
      rst = 1'b1; req = '0; we = '0; addr = '0; wd = '0;
      @(posedge clk); #1;
      cyc(); cyc();
      rst = 1'b0;
      cyc();
      chk("reset_gnt", 32'(obs_g), 0);
      chk("reset_rvalid", 32'(obs_rv), 0);
      chk("reset_rdata", 32'(obs_rd), 0);
      chk("reset_vaddr", 32'(obs_addr), 0);

      // All four held (as writes): BG while held, then SPR, then CPU/DMA alternate.
      for (int i = 0; i < 4; i++) put(i, 1'b1, 16'(i), 16'(16'h1000 + i));
      for (int k = 0; k < 3; k++) begin cyc(); chk("all_bg", 32'(obs_g), 32'h1); end
      req[0] = 1'b0;
      cyc(); chk("all_spr", 32'(obs_g), 32'h2);
      req[1] = 1'b0;
      cyc(); chk("rr_cpu0", 32'(obs_g), 32'h4);
      cyc(); chk("rr_dma0", 32'(obs_g), 32'h8);
      cyc(); chk("rr_cpu1", 32'(obs_g), 32'h4);
      cyc(); chk("rr_dma1", 32'(obs_g), 32'h8);
      req = '0;

      // Preload the working set through the CPU port.
      for (int a = 0; a < 32; a++) begin
         put(2, 1'b1, 16'(a), (a == 0) ? 16'hFFFF : 16'($urandom));
         cyc();
      end
      put(2, 1'b1, 16'h0123, 16'hBEEF); cyc();
      req = '0;

      // Lone CPU read.
      put(2, 1'b0, 16'h0123, 16'h0);
      cyc(); chk("cpu_rd_gnt", 32'(obs_g), 32'h4);
      req = '0;
      cyc(); chk("cpu_rd_rvalid", 32'(obs_rv), 32'h4);
      chk("cpu_rd_data", 32'(obs_rd), 32'hBEEF);

      // SPR continuous vs CPU: CPU wins on its 9th waiting cycle.
      put(1, 1'b0, 16'h0005, 16'h0);
      put(2, 1'b0, 16'h0007, 16'h0);
      for (int k = 0; k < LIM; k++) begin cyc(); chk("starve_spr", 32'(obs_g), 32'h2); end
      cyc(); chk("starve_cpu", 32'(obs_g), 32'h4);
      req[2] = 1'b0;
      cyc(); chk("starve_spr_resume", 32'(obs_g), 32'h2);
      req = '0; cyc();

      // Write then read-after-write at the top address.
      put(2, 1'b1, 16'h7FFF, 16'h5A5A);
      cyc(); chk("top_wren", 32'(obs_wren), 1); chk("top_addr", 32'(obs_addr), 32'h7FFF);
      req = '0; put(3, 1'b0, 16'h7FFF, 16'h0);
      cyc(); chk("raw_gnt", 32'(obs_g), 32'h8);
      req = '0;
      cyc(); chk("raw_rvalid", 32'(obs_rv), 32'h8); chk("raw_data", 32'(obs_rd), 32'h5A5A);

      // Out-of-range write dropped, read answers zero.
      put(2, 1'b1, 16'h8000, 16'h1234);
      cyc(); chk("oor_wr_gnt", 32'(obs_g), 32'h4); chk("oor_wren", 32'(obs_wren), 0);
      put(2, 1'b0, 16'h8000, 16'h0);
      cyc(); req = '0;
      cyc(); chk("oor_rvalid", 32'(obs_rv), 32'h4); chk("oor_rdata", 32'(obs_rd), 0);

      // Reset right after a BG read grant.
      put(0, 1'b0, 16'h0010, 16'h0);
      cyc(); chk("rst_bg_gnt", 32'(obs_g), 32'h1);
      req = '0; rst = 1'b1;
      cyc(); chk("rst_no_rvalid", 32'(obs_rv), 0);
      rst = 1'b0;
      cyc();
      chk("post_rst_gnt", 32'(obs_g), 0);
      chk("post_rst_rvalid", 32'(obs_rv), 0);
      chk("post_rst_rdata", 32'(obs_rd), 0);
      chk("post_rst_wren", 32'(obs_wren), 0);
      chk("post_rst_vaddr", 32'(obs_addr), 0);
      chk("post_rst_vwdata", 32'(obs_wd), 0);

      // Random traffic: balanced phase, then SPR-heavy phase to provoke starvation.
      for (int ph = 0; ph < 2; ph++) begin
         if (ph == 0) pr = '{20, 30, 50, 50};
         else         pr = '{5, 85, 60, 60};
         for (int n = 0; n < 1500; n++) begin
            if (rst) begin rst = 1'b0; req = '0; end
            else if ($urandom_range(0, 399) == 0) rst = 1'b1;
            for (int i = 0; i < 4; i++) begin
               if (!req[i] || m_lastg == i) begin
                  req[i]  = ($urandom_range(0, 99) < pr[i]);
                  we[i]   = 1'($urandom_range(0, 1));
                  addr[i] = {($urandom_range(0, 7) == 0), 10'd0, 5'($urandom_range(0, 31))};
                  wd[i]   = 16'($urandom);
               end else if ($urandom_range(0, 15) == 0) begin
                  req[i] = 1'b0;
               end
            end
            m_lastg = -1;
            cyc();
         end
      end
      rst = 1'b0; req = '0;
      cyc(); cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
